// File: rtl/edge_pkg.sv
// Shared definitions for the Sobel edge pipeline: output modes, pipeline latency
// and the guard bits that size the gradient magnitude (DW + MAG_GUARD).
package edge_pkg;

    typedef enum logic [1:0] {
        MODE_BINARY = 2'd0,
        MODE_MAG    = 2'd1,
        MODE_PASS   = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    localparam int LATENCY   = 3;
    localparam int MAG_GUARD = 3;

endpackage

// File: rtl/line_buffer.sv
// Simple dual-port line store: one write port, one registered read port
// (read data appears the cycle after re; a same-address write returns old data).
module line_buffer #(
    parameter int DW    = 8,
    parameter int DEPTH = 1280,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // NOTE: the RAM and its read register have no reset so they map onto block RAM;
    // stale contents are hidden downstream by border forcing.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sobel_edge_param.sv
// 3x3 Sobel edge detector on a raster pixel stream: framing counters, two line
// buffers, gradient magnitude and a mode-selected output, fixed 3-cycle latency.
module sobel_edge_param
    import edge_pkg::*;
#(
    parameter int DW    = 8,
    parameter int IMG_W = 1280,
    parameter int IMG_H = 720
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DW-1:0]   din,
    input  logic            din_vld,
    input  logic            din_sop,
    input  logic            din_eop,
    input  logic [1:0]      mode,
    input  logic [DW+2:0]   thresh,
    output logic [DW-1:0]   dout,
    output logic            dout_vld,
    output logic            dout_sop,
    output logic            dout_eop,
    output logic            frame_err
);

    localparam int MW = DW + MAG_GUARD;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef struct packed {
        logic          vld;
        logic          sop;
        logic          eop;
        logic          border;
        mode_e         mode;
        logic [MW-1:0] thresh;
        logic [CW-1:0] col;
        logic [DW-1:0] pix;
    } s1_t;

    typedef struct packed {
        logic          vld;
        logic          sop;
        logic          eop;
        logic          border;
        logic          hit;
        mode_e         mode;
        logic [MW-1:0] mag;
        logic [DW-1:0] pix;
    } s2_t;

    logic          synced;
    logic [CW-1:0] col, cur_col, nxt_col;
    logic [RW-1:0] row, cur_row, nxt_row;
    logic          accept, err_now;
    mode_e         cfg_mode;
    logic [MW-1:0] cfg_thresh;
    s1_t           s1;
    s2_t           s2;
    logic [DW-1:0] lb1_q, lb2_q;
    logic [2:0][DW-1:0] win1, win0;    // columns c-1 and c-2, indexed by row offset
    logic [MW-1:0] mag;
    logic [DW-1:0] dout_nxt;

    function automatic logic [DW+1:0] tap_sum(input logic [DW-1:0] a, b, c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    function automatic logic [DW+1:0] abs_diff(input logic [DW+1:0] a, b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Position of the pixel on din: sop forces the origin, counters hold the expected spot.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cur_col = din_sop ? '0 : col;
        cur_row = din_sop ? '0 : row;
        nxt_col = cur_col + 1'b1;
        nxt_row = cur_row;
        if (din_eop) begin
            nxt_col = '0;
            nxt_row = '0;
        end else if (cur_col == COL_LAST) begin
            nxt_col = '0;
            nxt_row = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
        end
        accept  = din_vld && (din_sop || synced);
        err_now = accept && ((din_eop && !(cur_row == ROW_LAST && cur_col == COL_LAST)) ||
                             (din_sop && (col != '0 || row != '0)));
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            synced     <= 1'b0;
            col        <= '0;
            row        <= '0;
            cfg_mode   <= MODE_BINARY;
            cfg_thresh <= '0;
            frame_err  <= 1'b0;
            s1         <= '0;
        end else begin
            if (din_vld && din_sop) begin
                synced     <= 1'b1;
                cfg_mode   <= mode_e'(mode);
                cfg_thresh <= thresh;
            end
            if (accept) begin
                col <= nxt_col;
                row <= nxt_row;
            end
            frame_err  <= err_now;
            s1.vld     <= accept;
            s1.sop     <= accept && din_sop;
            s1.eop     <= accept && din_eop;
            s1.border  <= (cur_row < RW'(2)) || (cur_col < CW'(2));
            s1.mode    <= din_sop ? mode_e'(mode) : cfg_mode;
            s1.thresh  <= din_sop ? thresh : cfg_thresh;
            s1.col     <= cur_col;
            s1.pix     <= din;
        end
    end

    // lb1 holds row r-1; its old word cascades into lb2, which holds row r-2.
    line_buffer #(.DW(DW), .DEPTH(IMG_W)) u_lb1 (
        .clk(clk), .we(s1.vld), .waddr(s1.col), .wdata(s1.pix),
        .re(accept), .raddr(cur_col), .rdata(lb1_q)
    );

    line_buffer #(.DW(DW), .DEPTH(IMG_W)) u_lb2 (
        .clk(clk), .we(s1.vld), .waddr(s1.col), .wdata(lb1_q),
        .re(accept), .raddr(cur_col), .rdata(lb2_q)
    );

    // Window column 2 is {s1.pix, lb1_q, lb2_q}; columns 1 and 0 come from win1/win0.
    always_comb begin
        mag = {1'b0, abs_diff(tap_sum(lb2_q, lb1_q, s1.pix), tap_sum(win0[0], win0[1], win0[2]))}
            + {1'b0, abs_diff(tap_sum(win0[2], win1[2], s1.pix), tap_sum(win0[0], win1[0], lb2_q))};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win1 <= '0;
            win0 <= '0;
            s2   <= '0;
        end else begin
            if (s1.vld) begin
                win0 <= win1;
                win1 <= {s1.pix, lb1_q, lb2_q};
            end
            s2.vld    <= s1.vld;
            s2.sop    <= s1.sop;
            s2.eop    <= s1.eop;
            s2.border <= s1.border;
            s2.hit    <= (mag >= s1.thresh);
            s2.mode   <= s1.mode;
            s2.mag    <= mag;
            s2.pix    <= s1.pix;
        end
    end

    always_comb begin
        dout_nxt = '0;
        if (s2.vld) begin
            case (s2.mode)
                MODE_PASS: dout_nxt = s2.pix;
                MODE_MAG:  if (!s2.border) dout_nxt = (|s2.mag[MW-1:DW]) ? '1 : s2.mag[DW-1:0];
                default:   if (!s2.border && s2.hit) dout_nxt = '1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout     <= '0;
            dout_vld <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
        end else begin
            dout     <= dout_nxt;
            dout_vld <= s2.vld;
            dout_sop <= s2.sop;
            dout_eop <= s2.eop;
        end
    end

endmodule
